// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared constants and state type for the neuron controller
package neuron_pkg;

  localparam int BITWIDTH_DEF   = 12;
  localparam int NUM_INPUTS_DEF = 16;
  localparam int BW             = BITWIDTH_DEF + 1;
  localparam int WORD_W         = BW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_CAPTURE,
    S_VALID
  } state_t;

  // Neuron word is BITWIDTH+2 bits: BW = BITWIDTH+1 plus the sign position.
  function automatic int word_width(input int bitwidth);
    return bitwidth + 2;
  endfunction

endpackage

// File: rtl/neuron_ctrl_if.sv
// rtl/neuron_ctrl_if.sv - command, memory-read, neuron and result signals of the controller
interface neuron_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 14
);

  logic              start;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              n_clear;
  logic              n_en;
  logic [WORD_W-1:0] accum;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;

  modport master (
    input  start, len, accum, out_ready,
    output busy, rd_en, rd_addr, n_clear, n_en, out_valid, out_data
  );

  modport slave (
    output start, len, accum, out_ready,
    input  busy, rd_en, rd_addr, n_clear, n_en, out_valid, out_data
  );

endinterface

// File: rtl/neuron_ctrl.sv
// rtl/neuron_ctrl.sv - sequences one neuron evaluation: clear, stream L reads, capture result
module neuron_ctrl
  import neuron_pkg::*;
#(
  parameter int BITWIDTH   = BITWIDTH_DEF,
  parameter int NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int ADDR_W     = $clog2(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             rst,
  neuron_ctrl_if.master    bus
);

  localparam int              DATA_W  = word_width(BITWIDTH);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(NUM_INPUTS);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t            state, state_nx;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len_q;
  logic              n_en_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      len_q  <= '0;
      n_en_q <= 1'b0;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      // Memory read latency is one cycle, so the accumulate strobe trails rd_en.
      n_en_q <= (state == S_RUN);
      case (state)
        S_IDLE:    if (bus.start) len_q <= (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
        S_CLEAR:   cnt    <= '0;
        S_RUN:     cnt    <= cnt + ONE;
        S_CAPTURE: data_q <= bus.accum;
        default:   ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (bus.start) state_nx = S_CLEAR;
      S_CLEAR:   state_nx = (len_q == '0) ? S_CAPTURE : S_RUN;
      S_RUN:     if (cnt + ONE == len_q) state_nx = S_DRAIN;
      S_DRAIN:   state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_VALID;
      S_VALID:   if (bus.out_ready) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.rd_en     = (state == S_RUN);
  assign bus.rd_addr   = cnt[ADDR_W-1:0];
  assign bus.n_clear   = (state == S_CLEAR);
  assign bus.n_en      = n_en_q;
  assign bus.out_valid = (state == S_VALID);
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_neuron_ctrl.sv
// tb/tb_neuron_ctrl.sv - scoreboard bench for neuron_ctrl with a counting neuron stub
module tb_neuron_ctrl;

  localparam int NUM_INPUTS = 16;
  localparam int ADDR_W     = 4;
  localparam int WORD_W     = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   sb_q[$];

  always #5 clk = ~clk;

  neuron_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  neuron_ctrl #(
    .BITWIDTH  (12),
    .NUM_INPUTS(NUM_INPUTS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Neuron stub: counts accumulate strobes, cleared by n_clear or its own reset.
  always_ff @(posedge clk) begin
    if (rst || bus.n_clear) bus.accum <= '0;
    else if (bus.n_en)      bus.accum <= bus.accum + 14'd1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs !== exp) $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    else pass_cnt++;
  endtask

  task automatic run_eval(input int len_in, input int hold);
    int l, k, addr_exp, n_rd, n_en_cnt, overlap, bad_addr, bad_busy, exp_data, stable_err;
    l = (len_in > NUM_INPUTS) ? NUM_INPUTS : len_in;
    sb_q.push_back(l);
    addr_exp = 0; n_rd = 0; n_en_cnt = 0; overlap = 0; bad_addr = 0; bad_busy = 0; stable_err = 0;
    bus.out_ready = (hold == 0);
    bus.start = 1'b1;
    bus.len   = (ADDR_W+1)'(len_in);
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    while (!bus.out_valid && k < 200) begin
      if (bus.rd_en) begin
        if (int'(bus.rd_addr) != addr_exp) bad_addr++;
        addr_exp++;
        n_rd++;
      end
      if (bus.n_en) n_en_cnt++;
      if (bus.n_en && bus.n_clear) overlap++;
      if (!bus.busy) bad_busy++;
      @(negedge clk);
      k++;
    end
    check($sformatf("valid_latency_len%0d", len_in), k, (l == 0) ? 3 : l + 4);
    check("rd_en_cycles", n_rd, l);
    check("rd_addr_seq_errors", bad_addr, 0);
    check("n_en_cycles", n_en_cnt, l);
    check("clear_en_overlap", overlap, 0);
    check("busy_low_while_running", bad_busy, 0);
    exp_data = sb_q.pop_front();
    check($sformatf("out_data_len%0d", len_in), int'(bus.out_data), exp_data);
    for (int i = 0; i < hold; i++) begin
      bus.start = (i == 2);
      bus.len   = 5'd3;
      @(negedge clk);
      if (!bus.out_valid || int'(bus.out_data) != exp_data) stable_err++;
    end
    if (hold > 0) check("hold_stable", stable_err, 0);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_handshake", int'(bus.busy), 0);
    @(negedge clk);
    check("start_at_handshake_ignored", int'(bus.busy), 0);
  endtask

  task automatic reset_mid_run();
    int k;
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    bus.len   = 5'd8;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!(bus.rd_en && bus.rd_addr == 4'd3) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reach_rd_addr3", int'(k < 50), 1);
    rst = 1'b1; bus.start = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_rd_en",     int'(bus.rd_en), 0);
    check("rst_n_en",      int'(bus.n_en), 0);
    check("rst_n_clear",   int'(bus.n_clear), 0);
    check("rst_busy",      int'(bus.busy), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data",  int'(bus.out_data), 0);
    check("rst_rd_addr",   int'(bus.rd_addr), 0);
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("rst_start_overridden", int'(bus.busy), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("init_busy",      int'(bus.busy), 0);
    check("init_rd_en",     int'(bus.rd_en), 0);
    check("init_n_clear",   int'(bus.n_clear), 0);
    check("init_out_valid", int'(bus.out_valid), 0);
    check("init_out_data",  int'(bus.out_data), 0);
    rst = 1'b0;
    @(negedge clk);
    run_eval(5, 0);
    run_eval(0, 3);
    run_eval(20, 10);
    run_eval(1, 1);
    run_eval(16, 0);
    run_eval(int'($urandom_range(2, 15)), 2);
    reset_mid_run();
    run_eval(2, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/neuron_ctrl.md
NEURON_CTRL -- requirements
Module: neuron_ctrl

Interface
REQ-001 Parameter BITWIDTH, default 12, mantissa/exponent budget of the neuron number format; word width BW+1 = BITWIDTH+2 bits (14).
REQ-002 Parameter NUM_INPUTS, default 16, maximum inputs per neuron evaluation.
REQ-003 Parameter ADDR_W, default $clog2(NUM_INPUTS), read-address width.
REQ-004 clk  in  1  single clock, all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request one evaluation; sampled only in IDLE.
REQ-007 len  in  ADDR_W+1  number of inputs for this evaluation, sampled with start.
REQ-008 busy  out  1  high from accepted start until result handshake completes.
REQ-009 rd_en  out  1  read strobe to weight and data memories.
REQ-010 rd_addr  out  ADDR_W  shared read address for weight and data memories.
REQ-011 n_clear  out  1  drives neuron clear.
REQ-012 n_en  out  1  drives neuron en (accumulate).
REQ-013 accum  in  BW+1  neuron accumulator value.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 out_data  out  BW+1  registered result.

Function
REQ-017 States IDLE, CLEAR, RUN, DRAIN, CAPTURE, VALID; registered FSM.
REQ-018 IDLE: start=1 -> latch L = min(len, NUM_INPUTS), go CLEAR; start=0 -> stay.
REQ-019 CLEAR: n_clear=1 exactly one cycle; L=0 -> CAPTURE, else RUN with counter=0.
REQ-020 RUN: rd_en=1, rd_addr=counter, counter increments each cycle; after issuing address L-1 -> DRAIN.
REQ-021 Memories have one-cycle read latency; n_en SHALL be rd_en delayed one cycle, giving exactly L n_en cycles, the last one in DRAIN.
REQ-022 DRAIN: rd_en=0, n_en=1 (last element), -> CAPTURE.
REQ-023 CAPTURE: out_data <= accum, -> VALID; for L=0 captured value is 0 (neuron cleared).
REQ-024 VALID: out_valid=1, out_data stable; out_ready=1 -> IDLE, busy drops next cycle.
REQ-025 Latency: start accepted in cycle t0 -> out_valid first high in cycle t0+L+4 (L>=1), t0+3 (L=0).
REQ-026 start while busy ignored; len above NUM_INPUTS clamped, never wraps rd_addr.
REQ-027 n_clear and n_en never high in the same cycle; n_en never high outside RUN+1..DRAIN.
REQ-028 out_ready ignored when out_valid=0; start same cycle as completing handshake ignored (accepted only in IDLE).

Reset
REQ-029 rst forces IDLE, counter=0, busy=0, rd_en=0, n_clear=0, n_en=0, out_valid=0, out_data=0, from any state including mid-RUN.
REQ-030 Reset overrides start, out_ready in the same cycle; neuron is cleared by its own rst, controller issues no n_clear.

Structure
REQ-031 State enum and BW/word-width constants in shared package neuron_pkg.
REQ-032 No sub-module; neuron instantiated beside the controller by parent layer module.

Verification
REQ-033 Bench replaces neuron with stub: accum += 1 per n_en, reset by n_clear.
REQ-034 len=5, start at t0 -> rd_addr 0..4 on consecutive cycles, 5 n_en pulses, out_valid at t0+9, out_data=5.
REQ-035 len=0 -> no rd_en, no n_en, out_valid at t0+3, out_data=0.
REQ-036 len=20 with NUM_INPUTS=16 -> rd_addr 0..15, out_data=16.
REQ-037 out_ready held low 10 cycles -> out_valid, out_data stable; second start during wait ignored.
REQ-038 rst asserted mid-RUN (counter=3) -> all outputs 0 next cycle; subsequent len=2 evaluation gives out_data=2.
